const_register_pipe: RTL
========================

# const_register_pipe

Parametrised constant register for the pipelined CPU. It assembles multi-byte constants from successive instruction-stream bytes on `MemData` and queues them in a shallow FIFO, so constant fetch can run ahead of the stage that consumes them. The head constant is driven onto the 8-bit main bus (one selectable byte) or the full-width address bus through active-low tri-state enables. It sits between instruction memory and the main/address buses, next to the fetch stage.

## Interface
Parameters:
- `DATA_W`, 8, byte width of `MemData` and `MainBus`
- `BYTES`, 2, bytes per constant (≥1); constant width `CW = BYTES*DATA_W`
- `DEPTH`, 2, FIFO entries (≥1)

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `MemData`  in  DATA_W  instruction-stream byte
- `load`  in  1  capture `MemData` as the next constant byte
- `pop`  in  1  consumer has finished with the head constant
- `flush`  in  1  pipeline flush: discard partial assembly and all queued constants
- `byte_sel`  in  clog2(BYTES) (min 1)  byte of head driven on `MainBus`
- `a_main_n`  in  1  active-low output enable, `MainBus`
- `a_addr_n`  in  1  active-low output enable, `AddrBus`
- `MainBus`  inout  DATA_W  tri-state; head byte `byte_sel` when enabled, else Z
- `AddrBus`  inout  CW  tri-state; full head constant when enabled, else Z
- `empty`, `full`  out  1  FIFO status
- `count`  out  clog2(DEPTH+1)  occupied entries
- `overflow`, `underflow`  out  1  sticky error flags

## Operation
- Little-endian assembly: first `load` byte → bits [DATA_W-1:0], k-th → bits [k*DATA_W +: DATA_W]. Byte pointer `bptr` counts 0..BYTES-1, wraps to 0.
- On `load` with `bptr == BYTES-1`: assembled word (including current `MemData`) is pushed; assembly buffer is not cleared (overwritten by subsequent loads).
- Push with `full` and no `pop`: constant dropped, `overflow` set. Push with `full` and `pop`: both happen, `count` unchanged.
- `pop` with `empty`: ignored, `underflow` set. Push + pop with `empty`: push happens, pop ignored, `underflow` set.
- `flush`: `bptr`←0, `count`←0, flags cleared; overrides `load`/`pop` in the same cycle.
- Empty head reads as all zeros on both buses when enabled.
- `byte_sel` ≥ BYTES: drive zeros.
- Both enables low simultaneously: both buses driven (independent buses).
- Reset: `bptr`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0, `underflow`=0, FIFO storage zeroed; buses Z unless an enable is low (then zeros).

## Timing
- Capture/push/pop are registered; bus drive is combinational from head register and enables (no clock delay).
- Latency: final `load` at edge N → constant at head and `empty`=0 after edge N (visible in cycle N+1) when queue was empty.
- `pop` at edge N → next entry at head in cycle N+1.
- Back-to-back constants: one `load` per cycle sustains one constant per BYTES cycles.
- Status outputs registered, consistent with `count` in the same cycle.

## Structure
- Package `const_reg_pkg`: default `DATA_W`/`BYTES`/`DEPTH`, `clog2` helper function, byte-order constant.
- Sub-module `const_fifo` (CW-wide, DEPTH-deep, synchronous push/pop/flush, count/full/empty, sticky flags); top holds byte assembler and tri-state drivers.

## Test plan
- Reset, `a_main_n`=`a_addr_n`=1 → both buses Z, `empty`=1, `count`=0; enables low → buses 0x00 / 0x0000.
- `load` 0xAA then 0x55 (BYTES=2) → after second edge `AddrBus`=0x55AA, `MainBus`=0xAA (`byte_sel`=0), 0x55 (`byte_sel`=1).
- Push three constants 0x1111, 0x2222, 0x3333 with DEPTH=2, no pop → `full`=1, `overflow`=1, head 0x1111; pop twice → 0x2222 then empty.
- Full queue, final `load` and `pop` same cycle → `count` stays 2, head advances to 0x2222, no overflow.
- One byte loaded, then `flush` with `load` high → `bptr`=0, `count`=0; next two loads 0x34, 0x12 give 0x1234.
- `pop` on empty → `underflow`=1, `count`=0; held until `flush` or `rst`.

Source files
------------

// File: rtl/const_reg_pkg.sv
// Shared defaults and helpers for the constant register pipe.
package const_reg_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned BYTES_DEF  = 2;
  localparam int unsigned DEPTH_DEF  = 2;

  // First loaded byte lands in the least significant lane.
  localparam bit LITTLE_ENDIAN = 1'b1;

  // Ceiling log2 with a floor of one bit, so single-entry selectors still have a port.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/const_fifo.sv
// Shallow FIFO of assembled constants with sticky overflow/underflow flags.
module const_fifo
  import const_reg_pkg::*;
#(
  parameter int unsigned CW    = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [CW-1:0]               push_data,
  input  logic                        pop,
  input  logic                        flush,
  output logic [CW-1:0]               head_c,
  output logic [clog2(DEPTH+1)-1:0]   count,
  output logic                        empty,
  output logic                        full,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int unsigned PW   = clog2(DEPTH);
  localparam int unsigned CNTW = clog2(DEPTH + 1);

  logic [CW-1:0]   mem_q [DEPTH];
  logic [CW-1:0]   mem_d [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            empty_q, empty_d;
  logic            full_q, full_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            do_push_c, do_pop_c;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Next-state: flush wins; a pop frees a slot for a same-cycle push when full.
  always_comb begin
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    do_pop_c  = pop && !empty_q;
    do_push_c = push && (!full_q || do_pop_c);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (do_push_c) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (do_pop_c) rd_ptr_d = next_ptr(rd_ptr_q);
      count_d = count_q + CNTW'(do_push_c) - CNTW'(do_pop_c);
      if (push && full_q && !pop) ovf_d = 1'b1;
      if (pop && empty_q)         unf_d = 1'b1;
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == CNTW'(DEPTH));
  end

  // State registers; storage is cleared on reset only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign head_c    = empty_q ? '0 : mem_q[rd_ptr_q];
  assign count     = count_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: rtl/const_register_pipe.sv
// Byte assembler feeding a constant FIFO, with tri-state drive of the head constant.
module const_register_pipe
  import const_reg_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned BYTES  = BYTES_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           MemData,
  input  logic                        load,
  input  logic                        pop,
  input  logic                        flush,
  input  logic [clog2(BYTES)-1:0]     byte_sel,
  input  logic                        a_main_n,
  input  logic                        a_addr_n,
  inout  wire  [DATA_W-1:0]           MainBus,
  inout  wire  [BYTES*DATA_W-1:0]     AddrBus,
  output logic                        empty,
  output logic                        full,
  output logic [clog2(DEPTH+1)-1:0]   count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int unsigned CW  = BYTES * DATA_W;
  localparam int unsigned BSW = clog2(BYTES);

  logic [BSW-1:0]    bptr_q, bptr_d;
  logic [CW-1:0]     asm_q, asm_d;
  logic              push_c;
  logic [CW-1:0]     head_c;
  logic [DATA_W-1:0] main_byte_c;

  // Assembler: drop MemData into the lane at bptr; the last lane pushes the whole word.
  always_comb begin
    bptr_d = bptr_q;
    asm_d  = asm_q;
    push_c = 1'b0;
    if (flush) begin
      bptr_d = '0;
    end else if (load) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (bptr_q == BSW'(i)) begin
          asm_d[(LITTLE_ENDIAN ? i : BYTES - 1 - i) * DATA_W +: DATA_W] = MemData;
        end
      end
      if (bptr_q == BSW'(BYTES - 1)) begin
        push_c = 1'b1;
        bptr_d = '0;
      end else begin
        bptr_d = bptr_q + BSW'(1);
      end
    end
  end

  // Assembler registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bptr_q <= '0;
      asm_q  <= '0;
    end else begin
      bptr_q <= bptr_d;
      asm_q  <= asm_d;
    end
  end

  const_fifo #(
    .CW    (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .push_data (asm_d),
    .pop       (pop),
    .flush     (flush),
    .head_c    (head_c),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Main-bus byte picker; out-of-range selects read as zero.
  always_comb begin
    main_byte_c = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (byte_sel == BSW'(i)) main_byte_c = head_c[i*DATA_W +: DATA_W];
    end
  end

  assign MainBus = a_main_n ? {DATA_W{1'bz}} : main_byte_c;
  assign AddrBus = a_addr_n ? {CW{1'bz}}     : head_c;

endmodule
